mcpu_core_scoreboard: RTL and testbench
=======================================

MCPU_CORE_SCOREBOARD -- requirements
Module: mcpu_core_scoreboard

Interface
REQ-001 Parameter NLANES, default 4, number of issue/writeback lanes; only 4 is supported.
REQ-002 Parameter NGPR, default 32, number of GPRs tracked.
REQ-003 Parameter NPRED, default 3, number of predicate registers tracked.
REQ-004 clkrst_core_clk  in  1  the only clock; all state changes on its rising edge.
REQ-005 clkrst_core_rst  in  1  reset, asynchronous, active-high.
REQ-006 d2sb_valid  in  1  decode presents a bundle this cycle.
REQ-007 d2sb_rs_num0..3, d2sb_rt_num0..3  in  5 each  source GPR numbers per lane.
REQ-008 d2sb_rs_use0..3, d2sb_rt_use0..3  in  1 each  lane actually reads rs/rt.
REQ-009 d2sb_pred_use0..3  in  1 each  lane is predicated; d2sb_pred_num0..3 (in, 2 each) gives the predicate.
REQ-010 d2sb_rd_num0..3  in  5 each  destination number; bits [1:0] select the predicate for predicate writes.
REQ-011 d2sb_rd_we0..3, d2sb_pred_we0..3  in  1 each  lane writes a GPR / predicate.
REQ-012 d2sb_long0..3  in  1 each  lane's result returns later (load, multi-cycle op).
REQ-013 wb2sb_long_we0..3  in  1 each  long-op GPR result retires this cycle on lane n; wb2sb_long_pred_we0..3 (in, 1 each) does the same for predicates.
REQ-014 wb2sb_rd_num0..3  in  5 each  register number of the retiring long result.
REQ-015 sb2d_stall  out  1  bundle must not issue this cycle.
REQ-016 sb_idle  out  1  no register is pending.
REQ-017 sb_err  out  1  sticky: a long writeback retired to a register that was not pending.
REQ-018 sb_stall_cycles  out  32  count of cycles with d2sb_valid=1 and sb2d_stall=1.

Function
REQ-019 State: gpr_busy[31:0], pred_busy[2:0], err flag, stall counter; nothing else.
REQ-020 sb2d_stall is combinational and SHALL be 1 iff d2sb_valid=1 and any enabled lane meets one of these: an rs/rt source is busy; a used predicate is busy; its rd_we destination GPR is busy; or its pred_we destination predicate is busy.
REQ-021 Stall uses registered busy bits only; a same-cycle writeback does not clear the hazard (no bypass), so a dependent bundle issues one cycle after the retiring writeback.
REQ-022 Issue = d2sb_valid & ~sb2d_stall; on issue each lane with long=1 sets gpr_busy[rd_num] if rd_we=1 and pred_busy[rd_num[1:0]] if pred_we=1; the update is visible next cycle.
REQ-023 Duplicate long destinations inside one bundle set the bit once.
REQ-024 Each wb2sb_long_we lane clears gpr_busy[wb2sb_rd_num]; each wb2sb_long_pred_we lane clears pred_busy[wb2sb_rd_num[1:0]].
REQ-025 If a set and a clear hit the same bit in one cycle, the set wins.
REQ-026 Predicate number 3 is out of range: issue and writeback ignore it, and a predicate read of it never stalls.
REQ-027 A clear aimed at a bit that is already 0 leaves the bit at 0 and sets sb_err, which stays 1 until reset.
REQ-028 sb_idle = ~|gpr_busy & ~|pred_busy, registered state only.
REQ-029 sb_stall_cycles increments by 1 per stalled-valid cycle and saturates at 32'hFFFFFFFF.
REQ-030 Short (long=0) lanes never touch busy state.

Reset
REQ-031 While clkrst_core_rst=1: gpr_busy=0, pred_busy=0, sb_err=0, sb_stall_cycles=0, sb_idle=1, and sb2d_stall follows inputs against cleared state.
REQ-032 Reset asserted mid-operation discards all pending entries; long writebacks arriving after reset set sb_err.

Structure
REQ-033 Lane count, GPR count, predicate count and the invalid predicate index (3) live in the shared core package.
REQ-034 One sub-module, mcpu_core_sb_lanechk, SHALL hold the per-lane hazard check; it is instantiated 4 times and its outputs are ORed into the stall.

Verification
REQ-035 Bundle with lane0 long load to r5; next cycle bundle with lane2 reading rs=r5 -> stall=1 until the cycle after wb2sb_long_we0 with num=5, then issue; sb_stall_cycles equals the stall count.
REQ-036 Long write to p1 pending; bundle predicated on p1 -> stall; bundle predicated on p0 -> no stall.
REQ-037 Pending r7 with a writeback clearing r7 in the same cycle as an issue setting r7 -> gpr_busy[7]=1 afterwards.
REQ-038 Writeback to r9 while r9 is not pending -> sb_err=1 and stays 1; reset -> sb_err=0, sb_idle=1.
REQ-039 Two long lanes both target r3 -> a single busy bit; one writeback -> sb_idle=1, sb_err=0.

Source files
------------

// File: rtl/mcpu_core_scoreboard_pkg.sv
// Shared constants and per-lane request type for the MCPU core register scoreboard.
package mcpu_core_scoreboard_pkg;

    localparam int unsigned SB_NLANES = 4;
    localparam int unsigned SB_NGPR   = 32;
    localparam int unsigned SB_NPRED  = 3;

    // Predicate index 3 does not exist; it never stalls, sets or clears.
    localparam logic [1:0] PRED_INVALID = 2'd3;

    typedef logic [4:0] reg_num_t;
    typedef logic [1:0] pred_num_t;

    typedef struct packed {
        reg_num_t  rs_num;
        reg_num_t  rt_num;
        reg_num_t  rd_num;
        pred_num_t pred_num;
        logic      rs_use;
        logic      rt_use;
        logic      pred_use;
        logic      rd_we;
        logic      pred_we;
    } lane_req_t;

endpackage

// File: rtl/mcpu_core_scoreboard_if.sv
// Decode/writeback-to-scoreboard bundle: per-lane packed fields plus scoreboard status.
interface mcpu_core_scoreboard_if;
    import mcpu_core_scoreboard_pkg::*;

    logic                             d2sb_valid;
    logic [SB_NLANES-1:0][4:0]        d2sb_rs_num;
    logic [SB_NLANES-1:0][4:0]        d2sb_rt_num;
    logic [SB_NLANES-1:0]             d2sb_rs_use;
    logic [SB_NLANES-1:0]             d2sb_rt_use;
    logic [SB_NLANES-1:0]             d2sb_pred_use;
    logic [SB_NLANES-1:0][1:0]        d2sb_pred_num;
    logic [SB_NLANES-1:0][4:0]        d2sb_rd_num;
    logic [SB_NLANES-1:0]             d2sb_rd_we;
    logic [SB_NLANES-1:0]             d2sb_pred_we;
    logic [SB_NLANES-1:0]             d2sb_long;
    logic [SB_NLANES-1:0]             wb2sb_long_we;
    logic [SB_NLANES-1:0]             wb2sb_long_pred_we;
    logic [SB_NLANES-1:0][4:0]        wb2sb_rd_num;
    logic                             sb2d_stall;
    logic                             sb_idle;
    logic                             sb_err;
    logic [31:0]                      sb_stall_cycles;

    modport master (
        output d2sb_valid, d2sb_rs_num, d2sb_rt_num, d2sb_rs_use, d2sb_rt_use,
               d2sb_pred_use, d2sb_pred_num, d2sb_rd_num, d2sb_rd_we, d2sb_pred_we,
               d2sb_long, wb2sb_long_we, wb2sb_long_pred_we, wb2sb_rd_num,
        input  sb2d_stall, sb_idle, sb_err, sb_stall_cycles
    );

    modport slave (
        input  d2sb_valid, d2sb_rs_num, d2sb_rt_num, d2sb_rs_use, d2sb_rt_use,
               d2sb_pred_use, d2sb_pred_num, d2sb_rd_num, d2sb_rd_we, d2sb_pred_we,
               d2sb_long, wb2sb_long_we, wb2sb_long_pred_we, wb2sb_rd_num,
        output sb2d_stall, sb_idle, sb_err, sb_stall_cycles
    );

endinterface

// File: rtl/mcpu_core_sb_lanechk.sv
// Per-lane hazard check against registered busy bits: RAW on sources/predicate, WAW on destinations.
module mcpu_core_sb_lanechk
    import mcpu_core_scoreboard_pkg::*;
(
    input  lane_req_t            req,
    input  logic [SB_NGPR-1:0]   gpr_busy,
    input  logic [SB_NPRED-1:0]  pred_busy,
    output logic                 hazard
);

    logic src_hz;
    logic pred_hz;
    logic dst_hz;
    logic pdst_hz;

    always_comb begin
        src_hz  = (req.rs_use && gpr_busy[req.rs_num]) ||
                  (req.rt_use && gpr_busy[req.rt_num]);
        pred_hz = req.pred_use && (req.pred_num != PRED_INVALID) && pred_busy[req.pred_num];
        dst_hz  = req.rd_we && gpr_busy[req.rd_num];
        pdst_hz = req.pred_we && (req.rd_num[1:0] != PRED_INVALID) && pred_busy[req.rd_num[1:0]];
        hazard  = src_hz || pred_hz || dst_hz || pdst_hz;
    end

endmodule

// File: rtl/mcpu_core_scoreboard.sv
// Register scoreboard: tracks GPRs/predicates owed by long ops, stalls dependent bundles, no bypass.
module mcpu_core_scoreboard
    import mcpu_core_scoreboard_pkg::*;
#(
    parameter int unsigned NLANES = SB_NLANES,
    parameter int unsigned NGPR   = SB_NGPR,
    parameter int unsigned NPRED  = SB_NPRED
) (
    input  logic                  clkrst_core_clk,
    input  logic                  clkrst_core_rst,
    mcpu_core_scoreboard_if.slave sb
);

    logic [NGPR-1:0]   gpr_busy;
    logic [NPRED-1:0]  pred_busy;
    logic              err;
    logic [31:0]       stall_cnt;

    logic [NGPR-1:0]   gpr_set;
    logic [NGPR-1:0]   gpr_clr;
    logic [NPRED-1:0]  pred_set;
    logic [NPRED-1:0]  pred_clr;
    logic [NLANES-1:0] lane_hz;
    logic              stall;
    logic              issue;
    logic              clr_idle;

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        lane_req_t req;

        assign req = '{
            rs_num:   sb.d2sb_rs_num[l],
            rt_num:   sb.d2sb_rt_num[l],
            rd_num:   sb.d2sb_rd_num[l],
            pred_num: sb.d2sb_pred_num[l],
            rs_use:   sb.d2sb_rs_use[l],
            rt_use:   sb.d2sb_rt_use[l],
            pred_use: sb.d2sb_pred_use[l],
            rd_we:    sb.d2sb_rd_we[l],
            pred_we:  sb.d2sb_pred_we[l]
        };

        mcpu_core_sb_lanechk u_lanechk (
            .req       (req),
            .gpr_busy  (gpr_busy),
            .pred_busy (pred_busy),
            .hazard    (lane_hz[l])
        );
    end

    assign stall = sb.d2sb_valid && (|lane_hz);
    assign issue = sb.d2sb_valid && !stall;

    always_comb begin
        gpr_set  = '0;
        gpr_clr  = '0;
        pred_set = '0;
        pred_clr = '0;
        for (int unsigned l = 0; l < NLANES; l++) begin
            if (issue && sb.d2sb_long[l]) begin
                if (sb.d2sb_rd_we[l])
                    gpr_set[sb.d2sb_rd_num[l]] = 1'b1;
                if (sb.d2sb_pred_we[l] && (sb.d2sb_rd_num[l][1:0] != PRED_INVALID))
                    pred_set[sb.d2sb_rd_num[l][1:0]] = 1'b1;
            end
            if (sb.wb2sb_long_we[l])
                gpr_clr[sb.wb2sb_rd_num[l]] = 1'b1;
            if (sb.wb2sb_long_pred_we[l] && (sb.wb2sb_rd_num[l][1:0] != PRED_INVALID))
                pred_clr[sb.wb2sb_rd_num[l][1:0]] = 1'b1;
        end
    end

    // A clear of a bit that was not pending in registered state is a protocol error.
    assign clr_idle = (|(gpr_clr & ~gpr_busy)) || (|(pred_clr & ~pred_busy));

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            gpr_busy  <= '0;
            pred_busy <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            // OR-ing the set after the clear makes a same-cycle set win.
            gpr_busy  <= (gpr_busy & ~gpr_clr) | gpr_set;
            pred_busy <= (pred_busy & ~pred_clr) | pred_set;
            if (clr_idle)
                err <= 1'b1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign sb.sb2d_stall      = stall;
    assign sb.sb_idle         = ~(|gpr_busy) & ~(|pred_busy);
    assign sb.sb_err          = err;
    assign sb.sb_stall_cycles = stall_cnt;

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// Self-checking bench: reference model pushes expected stall/idle/err/count, DUT outputs popped and compared.
module tb_mcpu_core_scoreboard;
    import mcpu_core_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mcpu_core_scoreboard_if sb_if ();

    mcpu_core_scoreboard #(
        .NLANES (4),
        .NGPR   (32),
        .NPRED  (3)
    ) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .sb              (sb_if)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    bit          m_gpr[32];
    bit          m_pred[3];
    bit          m_err;
    logic [31:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pop_check(input logic [31:0] act);
        exp_t e;
        e = exp_q.pop_front();
        check_val(e.tag, act, e.val);
    endtask

    task automatic model_reset();
        foreach (m_gpr[i]) m_gpr[i] = 1'b0;
        foreach (m_pred[i]) m_pred[i] = 1'b0;
        m_err = 1'b0;
        m_cnt = 32'd0;
    endtask

    function automatic bit m_pbusy(input int n);
        return (n < 3) ? m_pred[n] : 1'b0;
    endfunction

    function automatic bit m_idle();
        bit any = 1'b0;
        foreach (m_gpr[i]) any |= m_gpr[i];
        foreach (m_pred[i]) any |= m_pred[i];
        return !any;
    endfunction

    function automatic bit m_stall();
        bit s = 1'b0;
        if (!sb_if.d2sb_valid) return 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (sb_if.d2sb_rs_use[l] && m_gpr[sb_if.d2sb_rs_num[l]]) s = 1'b1;
            if (sb_if.d2sb_rt_use[l] && m_gpr[sb_if.d2sb_rt_num[l]]) s = 1'b1;
            if (sb_if.d2sb_pred_use[l] && m_pbusy(int'(sb_if.d2sb_pred_num[l]))) s = 1'b1;
            if (sb_if.d2sb_rd_we[l] && m_gpr[sb_if.d2sb_rd_num[l]]) s = 1'b1;
            if (sb_if.d2sb_pred_we[l] && m_pbusy(int'(sb_if.d2sb_rd_num[l][1:0]))) s = 1'b1;
        end
        return s;
    endfunction

    task automatic model_update(input bit s);
        bit ng[32];
        bit np[3];
        int n;
        ng = m_gpr;
        np = m_pred;
        for (int l = 0; l < 4; l++) begin
            if (sb_if.wb2sb_long_we[l]) begin
                n = int'(sb_if.wb2sb_rd_num[l]);
                if (!m_gpr[n]) m_err = 1'b1;
                ng[n] = 1'b0;
            end
            if (sb_if.wb2sb_long_pred_we[l]) begin
                n = int'(sb_if.wb2sb_rd_num[l][1:0]);
                if (n < 3) begin
                    if (!m_pred[n]) m_err = 1'b1;
                    np[n] = 1'b0;
                end
            end
        end
        if (sb_if.d2sb_valid && !s) begin
            for (int l = 0; l < 4; l++) begin
                if (sb_if.d2sb_long[l] && sb_if.d2sb_rd_we[l])
                    ng[sb_if.d2sb_rd_num[l]] = 1'b1;
                n = int'(sb_if.d2sb_rd_num[l][1:0]);
                if (sb_if.d2sb_long[l] && sb_if.d2sb_pred_we[l] && n < 3)
                    np[n] = 1'b1;
            end
        end
        if (sb_if.d2sb_valid && s && m_cnt != 32'hFFFF_FFFF)
            m_cnt = m_cnt + 32'd1;
        m_gpr  = ng;
        m_pred = np;
    endtask

    // One clock: compare stall mid-cycle, then idle/err/count just after the rising edge.
    task automatic step(input string name);
        bit s;
        #1;
        s = m_stall();
        exp_q.push_back('{$sformatf("%s/stall", name), {31'd0, s}});
        pop_check({31'd0, sb_if.sb2d_stall});
        @(posedge clk);
        if (rst) model_reset();
        else model_update(s);
        exp_q.push_back('{$sformatf("%s/idle", name), {31'd0, m_idle()}});
        exp_q.push_back('{$sformatf("%s/err", name), {31'd0, m_err}});
        exp_q.push_back('{$sformatf("%s/stall_cycles", name), m_cnt});
        #1;
        pop_check({31'd0, sb_if.sb_idle});
        pop_check({31'd0, sb_if.sb_err});
        pop_check(sb_if.sb_stall_cycles);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        sb_if.d2sb_valid         = 1'b0;
        sb_if.d2sb_rs_num        = '0;
        sb_if.d2sb_rt_num        = '0;
        sb_if.d2sb_rs_use        = '0;
        sb_if.d2sb_rt_use        = '0;
        sb_if.d2sb_pred_use      = '0;
        sb_if.d2sb_pred_num      = '0;
        sb_if.d2sb_rd_num        = '0;
        sb_if.d2sb_rd_we         = '0;
        sb_if.d2sb_pred_we       = '0;
        sb_if.d2sb_long          = '0;
        sb_if.wb2sb_long_we      = '0;
        sb_if.wb2sb_long_pred_we = '0;
        sb_if.wb2sb_rd_num       = '0;
    endtask

    task automatic long_gpr(input int l, input logic [4:0] rd);
        sb_if.d2sb_valid     = 1'b1;
        sb_if.d2sb_long[l]   = 1'b1;
        sb_if.d2sb_rd_we[l]  = 1'b1;
        sb_if.d2sb_rd_num[l] = rd;
    endtask

    task automatic read_rs(input int l, input logic [4:0] r);
        sb_if.d2sb_valid     = 1'b1;
        sb_if.d2sb_rs_use[l] = 1'b1;
        sb_if.d2sb_rs_num[l] = r;
    endtask

    task automatic wb_gpr(input int l, input logic [4:0] r);
        sb_if.wb2sb_long_we[l] = 1'b1;
        sb_if.wb2sb_rd_num[l]  = r;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Reset state with a valid bundle reading r0: nothing pending, no stall.
        read_rs(0, 5'd0);
        step("reset");
        rst = 1'b0;

        // Long load to r5, dependent read stalls through the writeback cycle.
        clear_inputs(); long_gpr(0, 5'd5);          step("issue_r5");
        clear_inputs(); read_rs(2, 5'd5);           step("dep_r5_a");
        check_val("r5_pending_stall", {31'd0, sb_if.sb2d_stall}, 32'd1);
        step("dep_r5_b");
        wb_gpr(0, 5'd5);                            step("dep_r5_wb_nobypass");
        sb_if.wb2sb_long_we = '0;                   step("dep_r5_issue");
        check_val("r5_stall_cycles", sb_if.sb_stall_cycles, 32'd3);
        check_val("r5_idle", {31'd0, sb_if.sb_idle}, 32'd1);

        // Predicate p1 pending: p1 read stalls, p0 and p3 do not.
        clear_inputs();
        sb_if.d2sb_valid = 1'b1; sb_if.d2sb_long[1] = 1'b1;
        sb_if.d2sb_pred_we[1] = 1'b1; sb_if.d2sb_rd_num[1] = 5'd1;
        step("issue_p1");
        clear_inputs();
        sb_if.d2sb_valid = 1'b1; sb_if.d2sb_pred_use[0] = 1'b1; sb_if.d2sb_pred_num[0] = 2'd1;
        step("pred_p1");
        sb_if.d2sb_pred_num[0] = 2'd0;              step("pred_p0");
        check_val("p0_no_stall", {31'd0, sb_if.sb2d_stall}, 32'd0);
        sb_if.d2sb_pred_num[0] = 2'd3;              step("pred_p3");
        clear_inputs();
        sb_if.d2sb_valid = 1'b1; sb_if.d2sb_pred_we[3] = 1'b1; sb_if.d2sb_rd_num[3] = 5'd1;
        step("pred_waw_p1");
        clear_inputs();
        sb_if.wb2sb_long_pred_we[1] = 1'b1; sb_if.wb2sb_rd_num[1] = 5'd1;
        step("wb_p1");

        // Predicate 3 is ignored on issue and writeback; short lanes leave busy state alone.
        clear_inputs();
        sb_if.d2sb_valid = 1'b1; sb_if.d2sb_long[0] = 1'b1;
        sb_if.d2sb_pred_we[0] = 1'b1; sb_if.d2sb_rd_num[0] = 5'd3;
        sb_if.d2sb_rd_we[1] = 1'b1; sb_if.d2sb_rd_num[1] = 5'd4;
        step("issue_p3_short_r4");
        clear_inputs();
        sb_if.wb2sb_long_pred_we[2] = 1'b1; sb_if.wb2sb_rd_num[2] = 5'd3;
        step("wb_p3_ignored");

        // Two long lanes to r3 set one bit; one writeback clears it cleanly.
        clear_inputs(); long_gpr(1, 5'd3); long_gpr(3, 5'd3); step("dup_r3");
        clear_inputs();
        sb_if.d2sb_valid = 1'b1; sb_if.d2sb_rt_use[0] = 1'b1; sb_if.d2sb_rt_num[0] = 5'd3;
        step("rt_r3_stall");
        clear_inputs(); wb_gpr(2, 5'd3);            step("wb_r3");
        clear_inputs();                             step("after_wb_r3");
        check_val("r3_idle", {31'd0, sb_if.sb_idle}, 32'd1);
        check_val("r3_err", {31'd0, sb_if.sb_err}, 32'd0);

        // r7 pending: WAW bundle stalls while the writeback clears it.
        clear_inputs(); long_gpr(0, 5'd7);          step("issue_r7");
        clear_inputs(); long_gpr(2, 5'd7); wb_gpr(0, 5'd7); step("waw_r7_wb");
        clear_inputs(); long_gpr(2, 5'd7);          step("reissue_r7");
        clear_inputs(); wb_gpr(1, 5'd7);            step("wb_r7");
        // Same-cycle set and clear of r7: set wins, clear of a non-pending bit flags an error.
        clear_inputs(); long_gpr(0, 5'd7); wb_gpr(1, 5'd7); step("set_wins_r7");
        clear_inputs(); read_rs(3, 5'd7);           step("r7_still_busy");
        check_val("r7_busy_stall", {31'd0, sb_if.sb2d_stall}, 32'd1);
        check_val("r7_err", {31'd0, sb_if.sb_err}, 32'd1);
        clear_inputs(); rst = 1'b1; model_reset();  step("reset_after_r7");
        rst = 1'b0;

        // Writeback to r9 while idle: sticky error until reset.
        clear_inputs(); wb_gpr(3, 5'd9);            step("wb_r9_unpending");
        clear_inputs();                             step("err_sticky_a");
        step("err_sticky_b");
        check_val("r9_err_sticky", {31'd0, sb_if.sb_err}, 32'd1);
        rst = 1'b1; model_reset();                  step("reset_clears_err");
        check_val("reset_err", {31'd0, sb_if.sb_err}, 32'd0);
        check_val("reset_idle", {31'd0, sb_if.sb_idle}, 32'd1);
        rst = 1'b0;

        // Mid-operation reset drops pending r12; its later writeback is an error.
        clear_inputs(); long_gpr(0, 5'd12);         step("issue_r12");
        clear_inputs(); read_rs(1, 5'd12);
        #2; rst = 1'b1; model_reset();              step("midop_reset");
        rst = 1'b0;
        clear_inputs(); wb_gpr(0, 5'd12);           step("wb_r12_after_reset");
        check_val("r12_err", {31'd0, sb_if.sb_err}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
